// File: rtl/frame_bank_arbiter_pkg.sv
// Shared types for the triple-buffer frame bank scheduler: bank index,
// writer/host state encodings and the free-bank selection rule.
package fb_pkg;

    localparam int NUM_BANKS = 3;

    typedef logic [1:0] bank_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        H_IDLE = 2'd0,
        H_WAIT = 2'd1,
        H_HOLD = 2'd2
    } host_state_t;

    function automatic bank_t bank_inc(bank_t b);
        return (b == bank_t'(NUM_BANKS - 1)) ? bank_t'(0) : b + bank_t'(1);
    endfunction

    // Next bank for the writer: the following bank, or the one after it
    // when the following bank is the one the host is holding.
    function automatic bank_t next_free_bank(bank_t wr, logic held, bank_t rd);
        bank_t n1;
        n1 = bank_inc(wr);
        return (held && (n1 == rd)) ? bank_inc(n1) : n1;
    endfunction

endpackage

// File: rtl/frame_bank_arbiter_if.sv
// Writer/host side of the frame bank arbiter: host read handshake plus the
// writer bank select and frame interrupt.
interface frame_bank_arbiter_if;
    import fb_pkg::*;

    logic  rd_req;
    logic  rd_done;
    bank_t rd_bank;
    logic  rd_ack;
    logic  rd_held;
    bank_t wr_bank;
    logic  wr_en;
    logic  frame_irq;

    // master: host and capture writer; slave: the arbiter
    modport master (
        output rd_req, rd_done,
        input  rd_bank, rd_ack, rd_held, wr_bank, wr_en, frame_irq
    );

    modport slave (
        input  rd_req, rd_done,
        output rd_bank, rd_ack, rd_held, wr_bank, wr_en, frame_irq
    );

endinterface

// File: rtl/frame_bank_arbiter_sync_edge.sv
// Two-flop synchroniser for one asynchronous decoder sync input, with
// single-cycle rise/fall strobes on the synchronised level.
module sync_edge (
    input  logic clk_llc2,
    input  logic resetx,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour and the chain really
    // is three stages long.
    always_ff @(posedge clk_llc2 or negedge resetx) begin
        if (!resetx) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/frame_bank_arbiter.sv
// Triple-buffer bank scheduler between the SAA7111A sync inputs, the capture
// writer and the host read port. FRAME_STATS_EN enables frame/drop counters.
module frame_bank_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned MIN_LINES = 100,
    parameter int unsigned IRQ_LEN   = 2,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 clk_llc2,
    input  logic                 resetx,
    input  logic                 vref,
    input  logic                 href,
    input  logic                 odd,
    frame_bank_arbiter_if.slave  bus,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic [CNT_W-1:0]     drop_cnt
);

    localparam logic [7:0] MIN_LINES_C = 8'(MIN_LINES);
    localparam int         IRQ_W       = (IRQ_LEN < 2) ? 1 : $clog2(IRQ_LEN + 1);
    localparam logic [IRQ_W-1:0] IRQ_LOAD = IRQ_W'(IRQ_LEN);

    logic w_vref_s, w_vref_rise, w_vref_fall;
    logic w_odd_s, w_odd_rise, w_odd_fall;
    logic w_href_s, w_href_rise, w_href_fall;
    logic [4:0] w_unused_edges;

    sync_edge u_sync_vref (
        .clk_llc2 (clk_llc2), .resetx (resetx), .i_async (vref),
        .o_level  (w_vref_s), .o_rise (w_vref_rise), .o_fall (w_vref_fall)
    );

    sync_edge u_sync_odd (
        .clk_llc2 (clk_llc2), .resetx (resetx), .i_async (odd),
        .o_level  (w_odd_s), .o_rise (w_odd_rise), .o_fall (w_odd_fall)
    );

    sync_edge u_sync_href (
        .clk_llc2 (clk_llc2), .resetx (resetx), .i_async (href),
        .o_level  (w_href_s), .o_rise (w_href_rise), .o_fall (w_href_fall)
    );

    assign w_unused_edges = {w_vref_rise, w_vref_fall, w_odd_rise, w_odd_fall,
                             w_href_s ^ w_href_fall};

    // Odd-field window and its edges
    logic w_of, r_of_d, w_of_rise, w_of_fall;
    assign w_of      = w_odd_s & w_vref_s;
    assign w_of_rise = w_of & ~r_of_d;
    assign w_of_fall = ~w_of & r_of_d;

    always_ff @(posedge clk_llc2 or negedge resetx) begin
        if (!resetx) r_of_d <= 1'b0;
        else         r_of_d <= w_of;
    end

    wr_state_t   r_wr_state;
    host_state_t r_host_state;
    logic [7:0]  r_line_cnt;
    bank_t       r_wr_bank, r_rd_bank, r_latest;
    logic        r_wr_en, r_rd_ack, r_rd_held, r_latest_valid;
    logic [IRQ_W-1:0] r_irq_cnt;
    logic        w_commit, w_grant;

    assign w_commit = (r_wr_state == COMMIT);
    // A commit in the same cycle wins; the grant then picks up the new frame.
    assign w_grant  = (r_host_state == H_WAIT) && r_latest_valid && !w_commit;

    always_ff @(posedge clk_llc2 or negedge resetx) begin
        if (!resetx) begin
            r_wr_state <= IDLE;
            r_wr_en    <= 1'b0;
            r_line_cnt <= 8'd0;
            r_wr_bank  <= bank_t'(0);
        end else begin
            case (r_wr_state)
                IDLE: begin
                    if (w_of_rise) begin
                        r_wr_state <= FILL;
                        r_wr_en    <= 1'b1;
                        r_line_cnt <= 8'd0;
                    end
                end
                FILL: begin
                    if (w_of_fall) begin
                        r_wr_en    <= 1'b0;
                        r_wr_state <= (r_line_cnt >= MIN_LINES_C) ? COMMIT : IDLE;
                    end else if (w_href_rise && (r_line_cnt != 8'hFF)) begin
                        r_line_cnt <= r_line_cnt + 8'd1;
                    end
                end
                COMMIT: begin
                    // rd_held/rd_bank are registers, so a release in this
                    // same cycle is not yet visible here.
                    r_wr_bank  <= next_free_bank(r_wr_bank, r_rd_held, r_rd_bank);
                    r_wr_state <= IDLE;
                end
                default: r_wr_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_llc2 or negedge resetx) begin
        if (!resetx) begin
            r_latest       <= bank_t'(0);
            r_latest_valid <= 1'b0;
        end else if (w_commit) begin
            r_latest       <= r_wr_bank;
            r_latest_valid <= 1'b1;
        end else if (w_grant) begin
            r_latest_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_llc2 or negedge resetx) begin
        if (!resetx) begin
            r_host_state <= H_IDLE;
            r_rd_bank    <= bank_t'(0);
            r_rd_ack     <= 1'b0;
            r_rd_held    <= 1'b0;
        end else begin
            r_rd_ack <= 1'b0;
            case (r_host_state)
                H_IDLE: if (bus.rd_req) r_host_state <= H_WAIT;
                H_WAIT: begin
                    if (w_grant) begin
                        r_rd_bank    <= r_latest;
                        r_rd_ack     <= 1'b1;
                        r_rd_held    <= 1'b1;
                        r_host_state <= H_HOLD;
                    end
                end
                H_HOLD: begin
                    if (bus.rd_done) begin
                        r_rd_held    <= 1'b0;
                        r_host_state <= H_IDLE;
                    end
                end
                default: r_host_state <= H_IDLE;
            endcase
        end
    end

    // Retriggerable interrupt stretch
    always_ff @(posedge clk_llc2 or negedge resetx) begin
        if (!resetx)                r_irq_cnt <= '0;
        else if (w_commit)          r_irq_cnt <= IRQ_LOAD;
        else if (r_irq_cnt != '0)   r_irq_cnt <= r_irq_cnt - 1'b1;
    end

`ifdef FRAME_STATS_EN
    logic [CNT_W-1:0] r_frame_cnt, r_drop_cnt;
    logic w_short_drop, w_supersede;

    assign w_short_drop = (r_wr_state == FILL) && w_of_fall && (r_line_cnt < MIN_LINES_C);
    assign w_supersede  = w_commit && r_latest_valid;

    always_ff @(posedge clk_llc2 or negedge resetx) begin
        if (!resetx) begin
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_commit)                   r_frame_cnt <= r_frame_cnt + 1'b1;
            if (w_short_drop || w_supersede) r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign drop_cnt  = r_drop_cnt;
`else
    assign frame_cnt = '0;
    assign drop_cnt  = '0;
`endif

    assign bus.wr_bank   = r_wr_bank;
    assign bus.wr_en     = r_wr_en;
    assign bus.rd_bank   = r_rd_bank;
    assign bus.rd_ack    = r_rd_ack;
    assign bus.rd_held   = r_rd_held;
    assign bus.frame_irq = (r_irq_cnt != '0);

    a_no_overwrite: assert property (@(posedge clk_llc2) disable iff (!resetx)
        r_rd_held |-> (r_wr_bank != r_rd_bank));

    a_latest_apart: assert property (@(posedge clk_llc2) disable iff (!resetx)
        r_latest_valid |-> (r_latest != r_wr_bank));

    a_bank_range: assert property (@(posedge clk_llc2) disable iff (!resetx)
        (r_wr_bank <= bank_t'(2)) && (r_rd_bank <= bank_t'(2)) && (r_latest <= bank_t'(2)));

endmodule

// File: doc/frame_bank_arbiter.md
Name: frame_bank_arbiter

Overview:
- Triple-buffer bank scheduler for the 180x120 RGB565 capture path.
- Decides which of three on-chip image banks (0..2) the video writer fills, and which completed bank the Amazon2 host may read.
- Raises a frame-ready interrupt and guarantees that the writer never overwrites a bank the host holds.
- Sits between the SAA7111A sync inputs and the capture writer / host SRAM-interface address mux.

Parameters:
- MIN_LINES, 100, minimum href rising edges inside one odd field for the frame to be committed.
- IRQ_LEN, 2, length of the frame_irq pulse in clk_llc2 cycles.
- CNT_W, 8, width of the statistics counters.

Ports:
- clk_llc2  in  1  13.5 MHz decoder clock.
- resetx  in  1  asynchronous, active-low reset.
- vref  in  1  decoder vertical sync (async; 2-flop synchronised).
- href  in  1  decoder horizontal sync (async; 2-flop synchronised).
- odd  in  1  decoder odd-field flag (async; 2-flop synchronised).
- rd_req  in  1  host requests a fresh frame; level, held until rd_ack.
- rd_done  in  1  host finished with the held bank; 1-cycle pulse.
- wr_bank  out  2  bank the writer fills.
- wr_en  out  1  writer may store pixels (high in FILL only).
- rd_bank  out  2  bank granted to the host; valid while rd_held=1.
- rd_ack  out  1  1-cycle grant pulse.
- rd_held  out  1  host currently holds rd_bank.
- frame_irq  out  1  frame-committed pulse, IRQ_LEN cycles.
- frame_cnt  out  CNT_W  committed frames, wraps.
- drop_cnt  out  CNT_W  frames discarded as short or unread-overwritten, wraps.

Behaviour:
- Sync: vref, href and odd each pass through 2 flops.
  - of = odd_s & vref_s.
  - of_rise and of_fall are 1-cycle edge detects on of; href_rise likewise.
- Reset values: wr_bank=0, rd_bank=0, wr_en=0, rd_ack=0, rd_held=0, frame_irq=0, counters=0, latest_valid=0, line_cnt=0, writer FSM=IDLE, host FSM=H_IDLE.
- Writer FSM (IDLE, FILL, COMMIT):
  - IDLE: on of_rise, go to FILL and clear line_cnt.
  - FILL: wr_en=1; line_cnt increments on href_rise and saturates at 255. On of_fall, go to COMMIT if line_cnt>=MIN_LINES; otherwise go to IDLE and increment drop_cnt.
  - COMMIT, one cycle:
    - If latest_valid was already 1, increment drop_cnt (the unread frame is superseded).
    - latest <= wr_bank; latest_valid <= 1; frame_cnt++; start frame_irq.
    - wr_bank <= (wr_bank+1) mod 3, unless rd_held and that value equals rd_bank; in that case use (wr_bank+2) mod 3.
    - Then go to IDLE.
  - of_rise while in FILL or COMMIT is ignored.
- Host FSM (H_IDLE, H_WAIT, H_HOLD):
  - H_IDLE: on rd_req, go to H_WAIT.
  - H_WAIT: when latest_valid=1 and the writer is not in COMMIT:
    - rd_bank <= latest, latest_valid <= 0, rd_ack pulse, rd_held <= 1, go to H_HOLD.
    - Grant latency is 1 cycle after the condition holds.
  - H_HOLD: on rd_done, rd_held <= 0 and go to H_IDLE.
  - rd_req while in H_HOLD is ignored. rd_done outside H_HOLD is ignored.
- Simultaneous events:
  - COMMIT has priority over grant; the grant slips 1 cycle and then delivers the newly committed bank.
  - rd_done in the COMMIT cycle: wr_bank selection uses the pre-release rd_held/rd_bank.
- Invariants, checked by assertion:
  - wr_bank != rd_bank while rd_held.
  - latest != wr_bank while latest_valid.
  - Bank values are always <= 2.
- frame_irq:
  - Counter-driven pulse of exactly IRQ_LEN cycles.
  - A new COMMIT during an active pulse restarts the count.
- Reset asserted mid-FILL or mid-HOLD returns everything to reset values immediately; the partial frame is not counted.

Optional Feature:
- FRAME_STATS_EN
  - Defined: frame_cnt and drop_cnt behave as above.
  - Undefined: both counters are removed and their outputs are driven constant 0. All other behaviour is unchanged.

Decomposition:
- Shared package (fb_pkg):
  - bank_t (2-bit) type.
  - Writer-state and host-state enums.
  - NUM_BANKS=3 constant.
  - next_free_bank(wr, held, rd) function.
- One natural sub-module: sync_edge (2-flop synchroniser plus rise/fall detector), instantiated three times.

Test Plan:
1. Field with 120 href pulses inside of, no host activity:
   - COMMIT fires 3 sync cycles after of_fall.
   - wr_bank 0->1, frame_irq high 2 cycles, frame_cnt=1.
2. Field with 50 href pulses:
   - No COMMIT, wr_bank stays 0, drop_cnt=1, frame_irq stays 0.
3. rd_req after frame 1:
   - rd_ack 1 cycle later, rd_bank=0, rd_held=1.
   - Next good field commits bank 1; wr_bank becomes 2.
   - Following field: wr_bank skips 0 and becomes 1.
4. rd_req asserted before any frame:
   - Host waits in H_WAIT; rd_ack arrives 1 cycle after the first COMMIT, with rd_bank=0.
5. Two good frames with no read:
   - drop_cnt=1, frame_cnt=2; a later grant returns bank 1.
6. resetx pulsed low mid-FILL with rd_held=1:
   - All outputs return to reset values.
   - The next good field commits bank 0 with frame_cnt=1.
